piso_result_collector: RTL and testbench
========================================

Name: piso_result_collector

Overview:
- Receiving end of the result serializer (PISO) send interface.
- Accepts the serialized stream of output-matrix elements, one per beat, in row-major order: element C[r][c] is beat index r*M+c.
- Buffers one full N×M frame, then presents it one row per transfer to the host-side consumer over a valid/ready handshake.
- Sits between the array's PISO output and the result write-back path.

Parameters:
- N, 3, rows of result matrix C (rows of A)
- M, 3, columns of result matrix C (columns of B)
- DATA_W, 16, width of one result element
- TIMEOUT_CYC, 64, idle-gap limit in COLLECT; used only with COLLECT_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  serial element valid (driven by controller send)
- in_data  in  DATA_W  serial element
- in_ready  out  1  collector can accept a beat
- out_valid  out  1  row available
- out_ready  in  1  consumer accepts row
- out_data  out  M*DATA_W  row; element c occupies bits [c*DATA_W +: DATA_W]
- out_row  out  $clog2(N) (min 1)  index of the row on out_data
- frame_done  out  1  one-cycle pulse after the last row handshake
- overrun  out  1  sticky; a beat arrived while in_ready was low
- err_timeout  out  1  one-cycle pulse on a collect timeout

Behaviour:
- Reset: synchronous, active-high, dominates everything, and is honoured mid-frame in any state.
  - State returns to IDLE; the partial frame is discarded.
  - Element counter, row counter and buffer are cleared to 0.
  - Output values under reset: in_ready=1, out_valid=0, out_data=0, out_row=0, frame_done=0, overrun=0, err_timeout=0.
- Buffer: N*M words of DATA_W. Element counter width is $clog2(N*M+1).
- Beat acceptance: a beat is accepted when in_valid && in_ready. The accepted word is written to buffer[elem_cnt] and elem_cnt increments.
- States: IDLE, COLLECT, DRAIN.
- IDLE:
  - in_ready=1, out_valid=0.
  - An accepted beat stores element 0 and moves to COLLECT.
  - If N*M==1, that beat moves directly to DRAIN.
- COLLECT:
  - in_ready=1.
  - The beat that makes elem_cnt reach N*M-1, i.e. the last element, moves to DRAIN on the next edge.
  - elem_cnt resets to 0 on that transition; there is no wrap into a new frame.
- DRAIN:
  - in_ready=0, out_valid=1.
  - out_data = buffer row out_row. It is registered/stable while out_valid && !out_ready.
  - Each out_valid && out_ready handshake increments out_row.
  - The handshake on row N-1 moves to IDLE, resets out_row to 0, and pulses frame_done for one cycle in the following cycle.
  - First row latency: out_valid is asserted the cycle after the last element is accepted.
  - The consumer may hold out_ready high. Rows then drain one per cycle, so a full frame drains in N cycles.
- Backpressure: out_ready low holds DRAIN indefinitely. No input is accepted meanwhile.
- Overrun: in_valid=1 while in_ready=0 sets overrun, which stays set until rst. The beat is dropped and no state changes.
- Simultaneous last-row handshake and in_valid: in_ready is still 0 in that cycle, so the beat is dropped and flagged as overrun. The new frame may start only from the following cycle.
- in_data is ignored whenever the beat is not accepted.

Optional Feature:
- Macro: COLLECT_TIMEOUT_EN.
- Defined:
  - A gap counter (width $clog2(TIMEOUT_CYC+1)) runs in COLLECT and clears on every accepted beat.
  - If it reaches TIMEOUT_CYC, the block returns to IDLE, clears elem_cnt, discards the partial frame, and pulses err_timeout for one cycle.
  - The gap counter is inactive in IDLE and DRAIN.
- Not defined: no gap counter; COLLECT waits indefinitely; err_timeout is tied to 0.

Test Plan:
- Basic frame (N=M=3, DATA_W=16): stream 9 beats back-to-back with values 1..9, out_ready=1. Required: out_valid rises the cycle after beat 9; rows are {1,2,3},{4,5,6},{7,8,9} with out_row 0,1,2 on consecutive cycles; frame_done pulses once; in_ready returns to 1.
- Backpressure: same frame with out_ready=0 for 5 cycles after DRAIN entry. Required: out_data={1,2,3} and out_row=0 held stable; then rows drain normally once out_ready=1.
- Overrun: drive in_valid=1 with value 0xAA during DRAIN. Required: overrun=1 and sticky; buffer rows unchanged; the next frame after frame_done is collected correctly.
- Gapped input: 9 beats with 2 idle cycles between each. Required: same rows as the basic frame; no err_timeout.
- Reset mid-frame: rst after beat 5, then a fresh 9-beat frame with values 11..19. Required: rows {11,12,13},{14,15,16},{17,18,19}; no stale data; overrun=0.
- With COLLECT_TIMEOUT_EN and TIMEOUT_CYC=8: send 4 beats, then idle for 8 cycles. Required: err_timeout pulses once; state is IDLE; a following full frame drains correctly.

Source files
------------

// File: rtl/piso_result_collector_if.sv
// Bundles the serial beat input and row output handshakes of the PISO result collector.
interface piso_result_collector_if #(
    parameter int N      = 3,
    parameter int M      = 3,
    parameter int DATA_W = 16
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [M*DATA_W-1:0]   out_data;
    logic [RW-1:0]         out_row;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_row
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_row
    );
endinterface

// File: rtl/piso_result_collector.sv
// Collects a row-major N x M result frame from the PISO stream and drains it one row per handshake.
// Optional macro COLLECT_TIMEOUT_EN enables an idle-gap timeout while collecting.
module piso_result_collector #(
    parameter int N           = 3,
    parameter int M           = 3,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    piso_result_collector_if.slave  bus,
    output logic                    frame_done,
    output logic                    overrun,
    output logic                    err_timeout
);
    localparam int NM = N * M;
    localparam int EW = $clog2(NM + 1);
    localparam int AW = (NM > 1) ? $clog2(NM) : 1;
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam logic [EW-1:0] LAST_ELEM = EW'(NM - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(N - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t                 state_q;
    logic [EW-1:0]          elem_cnt_q;
    logic [RW-1:0]          row_q;
    logic [NM*DATA_W-1:0]   buf_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   frame_done_q;
    logic                   overrun_q;
    logic                   accept;
    logic [AW-1:0]          wr_idx;

`ifdef COLLECT_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYC - 1);
    logic [GW-1:0]          gap_q;
    logic                   err_timeout_q;
`endif

    assign accept = bus.in_valid && in_ready_q;
    assign wr_idx = elem_cnt_q[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            elem_cnt_q   <= '0;
            row_q        <= '0;
            buf_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef COLLECT_TIMEOUT_EN
            gap_q         <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            frame_done_q <= 1'b0;
`ifdef COLLECT_TIMEOUT_EN
            err_timeout_q <= 1'b0;
`endif
            // A beat offered while not ready is dropped but remembered until reset.
            if (bus.in_valid && !in_ready_q) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        buf_q[DATA_W-1:0] <= bus.in_data;
                        if (NM == 1) begin
                            state_q     <= DRAIN;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q    <= COLLECT;
                            elem_cnt_q <= EW'(1);
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        buf_q[wr_idx*DATA_W +: DATA_W] <= bus.in_data;
`ifdef COLLECT_TIMEOUT_EN
                        gap_q <= '0;
`endif
                        if (elem_cnt_q == LAST_ELEM) begin
                            elem_cnt_q  <= '0;
                            state_q     <= DRAIN;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            elem_cnt_q <= elem_cnt_q + 1'b1;
                        end
                    end
`ifdef COLLECT_TIMEOUT_EN
                    else if (gap_q == GAP_LAST) begin
                        state_q       <= IDLE;
                        elem_cnt_q    <= '0;
                        gap_q         <= '0;
                        err_timeout_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        if (row_q == LAST_ROW) begin
                            row_q        <= '0;
                            state_q      <= IDLE;
                            in_ready_q   <= 1'b1;
                            out_valid_q  <= 1'b0;
                            frame_done_q <= 1'b1;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = row_q;
    assign bus.out_data  = out_valid_q ? buf_q[row_q*(M*DATA_W) +: M*DATA_W] : '0;
    assign frame_done    = frame_done_q;
    assign overrun       = overrun_q;

`ifdef COLLECT_TIMEOUT_EN
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_piso_result_collector.sv
// Bench for piso_result_collector: frame table plus scoreboard of expected rows.
module tb_piso_result_collector;
    localparam int N  = 3;
    localparam int M  = 3;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    logic frame_done, overrun, err_timeout;

    piso_result_collector_if #(.N(N), .M(M), .DATA_W(DW)) bus ();

    piso_result_collector #(.N(N), .M(M), .DATA_W(DW), .TIMEOUT_CYC(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      row;
        logic [M*DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int base;
        int gap;
        int bp;
        bit poke;
        bit exp_ov;
    } vec_t;
    vec_t tbl[5];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [M*DW-1:0] row_val(input int base, input int r);
        logic [M*DW-1:0] d;
        for (int c = 0; c < M; c++) d[c*DW +: DW] = DW'(base + r*M + c);
        return d;
    endfunction

    // Every row handshake is matched against the oldest expected row.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_row", 64'(bus.out_row), 64'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("row_index", 64'(bus.out_row), 64'(e.row));
                check("row_data", 64'(bus.out_data), 64'(e.data));
            end
        end
    end

    task automatic send_beats(input int base, input int from, input int to, input int gap);
        for (int i = from; i < to; i++) begin
            if (i == N*M - 1) begin
                for (int r = 0; r < N; r++) begin
                    exp_t e;
                    e.row  = 2'(r);
                    e.data = row_val(base, r);
                    exp_q.push_back(e);
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(base + i);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
            if (i != to - 1) repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain(input int base, input int bp, input bit poke);
        int fd;
        check("first_row_latency", 64'(bus.out_valid), 64'd1);
        for (int k = 0; k < bp; k++) begin
            check("bp_hold_row", 64'(bus.out_row), 64'd0);
            check("bp_hold_data", 64'(bus.out_data), 64'(row_val(base, 0)));
            if (poke && k == 1) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 16'h00AA;
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
        end
        if (poke) check("overrun_set", 64'(overrun), 64'd1);
        bus.out_ready = 1'b1;
        fd = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (frame_done) fd++;
        end
        check("frame_done_count", 64'(fd), 64'd1);
        check("in_ready_back", 64'(bus.in_ready), 64'd1);
        check("rows_all_seen", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int et;
        tbl[0] = '{base: 1,  gap: 0, bp: 0, poke: 1'b0, exp_ov: 1'b0};
        tbl[1] = '{base: 1,  gap: 2, bp: 0, poke: 1'b0, exp_ov: 1'b0};
        tbl[2] = '{base: 1,  gap: 0, bp: 5, poke: 1'b0, exp_ov: 1'b0};
        tbl[3] = '{base: 1,  gap: 0, bp: 5, poke: 1'b1, exp_ov: 1'b1};
        tbl[4] = '{base: 31, gap: 1, bp: 0, poke: 1'b0, exp_ov: 1'b1};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_row", 64'(bus.out_row), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_err_timeout", 64'(err_timeout), 64'd0);
        rst = 1'b0;

        for (int t = 0; t < 5; t++) begin
            bus.out_ready = (tbl[t].bp == 0);
            et = 0;
            send_beats(tbl[t].base, 0, N*M, tbl[t].gap);
            drain(tbl[t].base, tbl[t].bp, tbl[t].poke);
            check("overrun_state", 64'(overrun), 64'(tbl[t].exp_ov));
            check("no_timeout", 64'(err_timeout), 64'd0);
        end

        // Reset in the middle of a frame discards the partial data and clears overrun.
        send_beats(100, 0, 5, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_overrun", 64'(overrun), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        send_beats(11, 0, N*M, 0);
        drain(11, 0, 1'b0);
        check("midrst_overrun_after", 64'(overrun), 64'd0);

        // Idle gap after a partial frame.
        send_beats(50, 0, 4, 0);
        et = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (err_timeout) et++;
            if (bus.out_valid) check("gap_out_valid", 64'(bus.out_valid), 64'd0);
        end
        check("gap_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef COLLECT_TIMEOUT_EN
        check("timeout_pulses", 64'(et), 64'd1);
        send_beats(60, 0, N*M, 0);
        drain(60, 0, 1'b0);
`else
        check("timeout_pulses", 64'(et), 64'd0);
        send_beats(50, 4, N*M, 0);
        drain(50, 0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
